// File: rtl/pcap_dma_pkg.sv
// pcap_dma_pkg: shared types and constants for the capture DMA block.
// Holds the controller state enum, the irq_status flag bit positions,
// the status word field offsets and a helper that packs a status word.
package pcap_dma_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_BUF = 2'd1,
    ST_FILL     = 2'd2
  } state_e;

  // irq_status_o flag bit positions
  localparam int FLAG_W         = 7;
  localparam int FLG_BLOCK_DONE = 0;
  localparam int FLG_COMPLETED  = 1;
  localparam int FLG_DISARMED   = 2;
  localparam int FLG_NO_BUFFER  = 3;
  localparam int FLG_TABLE_OVF  = 4;
  localparam int FLG_TIMEOUT    = 5;
  localparam int FLG_IRQ_LOST   = 6;

  // irq_status_o word count field
  localparam int STAT_CNT_LSB = 16;
  localparam int STAT_CNT_W   = 16;

  function automatic logic [31:0] mk_status(input logic [STAT_CNT_W-1:0] cnt,
                                            input logic [FLAG_W-1:0]     flags);
    logic [31:0] s;
    s = '0;
    s[STAT_CNT_LSB +: STAT_CNT_W] = cnt;
    s[FLAG_W-1:0]                 = flags;
    return s;
  endfunction

endpackage

// File: rtl/pcap_addr_fifo.sv
// pcap_addr_fifo: circular FIFO of buffer base addresses.
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   push, wr_data       enqueue (dropped when full unless popped same cycle)
//   pop, rd_data        dequeue; rd_data always shows the head entry
//   level, full, empty  occupancy
module pcap_addr_fifo #(
  parameter int DEPTH = 32,
  parameter int WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       rd_data,
  output logic [$clog2(DEPTH):0] level,
  output logic                   full,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign full  = (level == LW'(DEPTH));
  assign empty = (level == '0);

  // A push into a full FIFO is accepted when the head leaves on the same edge.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      level <= level + LW'(do_push) - LW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/pcap_dma_table.sv
// pcap_dma_table: capture-stream DMA engine driven by a table of buffer
// base addresses. Samples are written word by word into the current buffer;
// when a buffer fills the next base is taken from the table with no bubble.
// Ports:
//   clk_i, reset_i                 clock, synchronous active-high reset
//   addr_wr_i, addr_i              push a buffer base address
//   block_size_i                   words per buffer (0 = 2^COUNT_W)
//   arm_i, disarm_i                capture control pulses
//   smpl_valid_i/last_i/data_i     sample stream
//   dma_wr_o, dma_addr_o, dma_data_o  registered write request
//   irq_o, irq_status_o, irq_ack_i interrupt, status {count, flags}, ack
//   armed_o, table_level_o         status
//   timeout_i                      idle timeout in cycles (only with
//                                  PCAP_DMA_TIMEOUT_EN defined)
module pcap_dma_table
  import pcap_dma_pkg::*;
#(
  parameter int TABLE_DEPTH = 32,
  parameter int DATA_W      = 32,
  parameter int COUNT_W     = 16
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic                         addr_wr_i,
  input  logic [31:0]                  addr_i,
  input  logic [COUNT_W-1:0]           block_size_i,
  input  logic                         arm_i,
  input  logic                         disarm_i,
  input  logic                         smpl_valid_i,
  input  logic                         smpl_last_i,
  input  logic [DATA_W-1:0]            smpl_data_i,
`ifdef PCAP_DMA_TIMEOUT_EN
  input  logic [31:0]                  timeout_i,
`endif
  output logic                         dma_wr_o,
  output logic [31:0]                  dma_addr_o,
  output logic [DATA_W-1:0]            dma_data_o,
  output logic                         irq_o,
  output logic [31:0]                  irq_status_o,
  input  logic                         irq_ack_i,
  output logic                         armed_o,
  output logic [$clog2(TABLE_DEPTH):0] table_level_o
);

  localparam int CW  = COUNT_W + 1;  // holds 2^COUNT_W for block_size 0
  localparam int BPW = DATA_W / 8;

  state_e            state, nxt_state;
  logic [CW-1:0]     count, nxt_count, cnt_inc, blk_words, ev_count;
  logic [31:0]       base, nxt_base, wr_addr;
  logic              fifo_pop, fifo_full, fifo_empty, ovf, advance, wr_nxt;
  logic [31:0]       head;
  logic [FLAG_W-1:0] sm_flags, ev_flags, lost_flag;
  logic              ev;

  pcap_addr_fifo #(
    .DEPTH (TABLE_DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .clk     (clk_i),
    .reset   (reset_i),
    .push    (addr_wr_i),
    .wr_data (addr_i),
    .pop     (fifo_pop),
    .rd_data (head),
    .level   (table_level_o),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign blk_words = (block_size_i == '0) ? {1'b1, {COUNT_W{1'b0}}}
                                          : {1'b0, block_size_i};
  assign cnt_inc   = count + 1'b1;
  assign wr_addr   = base + 32'(count) * 32'(BPW);
  assign ovf       = addr_wr_i & fifo_full & ~fifo_pop;
  assign armed_o   = (state != ST_IDLE);

`ifdef PCAP_DMA_TIMEOUT_EN
  logic [31:0] idle_cnt;
  logic        tmo_run, tmo_hit;

  // Runs only while a partially filled buffer is waiting for samples.
  assign tmo_run = (state == ST_FILL) && (count != '0) && !smpl_valid_i;
  assign tmo_hit = tmo_run && (timeout_i != '0) && (idle_cnt + 32'd1 == timeout_i);

  always_ff @(posedge clk_i) begin
    if (reset_i)                 idle_cnt <= '0;
    else if (tmo_run && !tmo_hit) idle_cnt <= idle_cnt + 32'd1;
    else                         idle_cnt <= '0;
  end
`endif

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state <= ST_IDLE;
      count <= '0;
      base  <= '0;
    end else begin
      state <= nxt_state;
      count <= nxt_count;
      base  <= nxt_base;
    end
  end

  always_comb begin
    nxt_state = state;
    nxt_count = count;
    nxt_base  = base;
    fifo_pop  = 1'b0;
    wr_nxt    = 1'b0;
    advance   = 1'b0;
    sm_flags  = '0;
    ev_count  = count;

    case (state)
      ST_IDLE: begin
        if (arm_i) begin
          nxt_state = ST_WAIT_BUF;
          nxt_count = '0;
        end
      end
      ST_WAIT_BUF: begin
        if (!fifo_empty) begin
          fifo_pop  = 1'b1;
          nxt_base  = head;
          nxt_count = '0;
          nxt_state = ST_FILL;
        end
        // No buffer is loaded until FILL, so any sample here is lost.
        if (smpl_valid_i) sm_flags[FLG_NO_BUFFER] = 1'b1;
      end
      ST_FILL: begin
        if (smpl_valid_i) begin
          wr_nxt   = 1'b1;
          ev_count = cnt_inc;
          if (smpl_last_i) begin
            sm_flags[FLG_COMPLETED] = 1'b1;
            nxt_count = cnt_inc;
            nxt_state = ST_IDLE;
          end else if (cnt_inc == blk_words) begin
            sm_flags[FLG_BLOCK_DONE] = 1'b1;
            advance = 1'b1;
          end else begin
            nxt_count = cnt_inc;
          end
        end
`ifdef PCAP_DMA_TIMEOUT_EN
        else if (tmo_hit) begin
          sm_flags[FLG_TIMEOUT]    = 1'b1;
          sm_flags[FLG_BLOCK_DONE] = 1'b1;
          advance = 1'b1;
        end
`endif
      end
      default: nxt_state = ST_IDLE;
    endcase

    // Close the current buffer: chain straight into the next one if queued.
    if (advance) begin
      nxt_count = '0;
      if (!fifo_empty) begin
        fifo_pop = 1'b1;
        nxt_base = head;
      end else begin
        nxt_state = ST_WAIT_BUF;
      end
    end

    // Disarm overrides everything the state machine decided this cycle.
    if (disarm_i) begin
      nxt_state = ST_IDLE;
      nxt_count = count;
      nxt_base  = base;
      fifo_pop  = 1'b0;
      wr_nxt    = 1'b0;
      sm_flags  = '0;
      sm_flags[FLG_DISARMED] = 1'b1;
      ev_count  = count;
    end

    ev_flags = sm_flags;
    ev_flags[FLG_TABLE_OVF] = ovf;
    ev = |ev_flags;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      dma_wr_o   <= 1'b0;
      dma_addr_o <= '0;
      dma_data_o <= '0;
    end else begin
      dma_wr_o <= wr_nxt;
      if (wr_nxt) begin
        dma_addr_o <= wr_addr;
        dma_data_o <= smpl_data_i;
      end
    end
  end

  assign lost_flag = FLAG_W'(1) << FLG_IRQ_LOST;

  // An event on top of a pending, unacked irq accumulates its flags and
  // marks IRQ_LOST; an ack in the same cycle makes room for a fresh status.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      irq_o        <= 1'b0;
      irq_status_o <= '0;
    end else if (ev) begin
      irq_o <= 1'b1;
      if (irq_o && !irq_ack_i)
        irq_status_o <= mk_status(STAT_CNT_W'(ev_count),
                                  irq_status_o[FLAG_W-1:0] | ev_flags | lost_flag);
      else
        irq_status_o <= mk_status(STAT_CNT_W'(ev_count), ev_flags);
    end else if (irq_ack_i) begin
      irq_o        <= 1'b0;
      irq_status_o <= '0;
    end
  end

endmodule

// File: tb/tb_pcap_dma_table.sv
module tb_pcap_dma_table;

  logic        clk = 1'b0;
  logic        reset;
  logic        addr_wr;
  logic [31:0] addr;
  logic [15:0] block_size;
  logic        arm, disarm;
  logic        smpl_valid, smpl_last;
  logic [31:0] smpl_data;
  logic        dma_wr;
  logic [31:0] dma_addr, dma_data;
  logic        irq, irq_ack;
  logic [31:0] irq_status;
  logic        armed;
  logic [5:0]  table_level;
`ifdef PCAP_DMA_TIMEOUT_EN
  logic [31:0] timeout;
`endif

  int n_cmp = 0;
  int n_err = 0;

  typedef struct packed { logic [31:0] a; logic [31:0] d; } wr_t;
  wr_t sb[$];

  always #5 clk = ~clk;

  pcap_dma_table #(.TABLE_DEPTH(32), .DATA_W(32), .COUNT_W(16)) dut (
    .clk_i         (clk),
    .reset_i       (reset),
    .addr_wr_i     (addr_wr),
    .addr_i        (addr),
    .block_size_i  (block_size),
    .arm_i         (arm),
    .disarm_i      (disarm),
    .smpl_valid_i  (smpl_valid),
    .smpl_last_i   (smpl_last),
    .smpl_data_i   (smpl_data),
`ifdef PCAP_DMA_TIMEOUT_EN
    .timeout_i     (timeout),
`endif
    .dma_wr_o      (dma_wr),
    .dma_addr_o    (dma_addr),
    .dma_data_o    (dma_data),
    .irq_o         (irq),
    .irq_status_o  (irq_status),
    .irq_ack_i     (irq_ack),
    .armed_o       (armed),
    .table_level_o (table_level)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Scoreboard: every DMA write must match the oldest expected write.
  always @(negedge clk) begin
    if (dma_wr === 1'b1) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_err++;
        $error("FAIL unexpected_wr got addr=%h exp none", dma_addr);
      end else begin
        wr_t e;
        e = sb.pop_front();
        chk("wr_addr", dma_addr, e.a);
        chk("wr_data", dma_data, e.d);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] a);
    addr_wr = 1'b1;
    addr    = a;
    tick();
    addr_wr = 1'b0;
  endtask

  task automatic pulse_arm();
    arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask

  task automatic ack();
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
  endtask

  task automatic sample(input logic [31:0] exp_addr, input logic last, input bit expect_wr);
    smpl_valid = 1'b1;
    smpl_last  = last;
    smpl_data  = $urandom;
    if (expect_wr) sb.push_back({exp_addr, smpl_data});
    tick();
    smpl_valid = 1'b0;
    smpl_last  = 1'b0;
  endtask

  initial begin
    reset = 1'b1; addr_wr = 0; addr = 0; block_size = 16'd4;
    arm = 0; disarm = 0; smpl_valid = 0; smpl_last = 0; smpl_data = 0; irq_ack = 0;
`ifdef PCAP_DMA_TIMEOUT_EN
    timeout = 0;
`endif
    repeat (3) tick();
    chk("rst_armed", armed, 0);
    chk("rst_level", table_level, 0);
    chk("rst_irq", irq, 0);
    chk("rst_status", irq_status, 0);
    chk("rst_dma_wr", dma_wr, 0);
    reset = 1'b0;
    tick();

    // Two buffers of 4 words, 8 samples back to back, zero-bubble chaining
    push(32'h1000);
    push(32'h2000);
    chk("lvl2", table_level, 2);
    pulse_arm();
    chk("armed", armed, 1);
    tick();
    chk("lvl_after_pop", table_level, 1);
    for (int i = 0; i < 8; i++) begin
      if (i == 4) irq_ack = 1'b1;
      sample((i < 4 ? 32'h1000 : 32'h2000) + 32'(i % 4) * 4, 1'b0, 1'b1);
      irq_ack = 1'b0;
      chk("no_gap", dma_wr, 1);
      if (i == 3) begin
        chk("bd1_irq", irq, 1);
        chk("bd1_status", irq_status, 32'h0004_0001);
      end
      if (i == 4) chk("ack_clr", irq, 0);
    end
    chk("bd2_status", irq_status, 32'h0004_0001);
    chk("wait_armed", armed, 1);
    ack();
    chk("ack_irq", irq, 0);

    // Empty table: samples dropped with NO_BUFFER, then a late buffer
    pulse_arm();
    sample(0, 1'b0, 1'b0);
    chk("nobuf1", irq_status, 32'h0000_0008);
    sample(0, 1'b0, 1'b0);
    sample(0, 1'b0, 1'b0);
    chk("nobuf3", irq_status, 32'h0000_0048);
    ack();
    push(32'h3000);
    tick();
    sample(32'h3000, 1'b0, 1'b1);
    chk("late_addr", dma_addr, 32'h3000);
    // disarm with a sample in the same cycle: disarm wins
    disarm = 1'b1; smpl_valid = 1'b1; smpl_data = $urandom;
    tick();
    disarm = 1'b0; smpl_valid = 1'b0;
    chk("disarm_status", irq_status, 32'h0001_0004);
    chk("disarm_armed", armed, 0);
    chk("disarm_nowr", dma_wr, 0);

    reset = 1'b1; tick(); reset = 1'b0;
    chk("rst2_irq", irq, 0);

    // Table overflow and push/pop at full
    for (int i = 0; i < 33; i++) begin
      push(32'h1_0000 + 32'(i) * 32'h100);
      if (i == 31) begin
        chk("full_lvl", table_level, 32);
        chk("full_noirq", irq, 0);
      end
    end
    chk("ovf_lvl", table_level, 32);
    chk("ovf_status", irq_status, 32'h0000_0010);
    ack();
    pulse_arm();
    push(32'h9_9000);
    chk("pushpop_lvl", table_level, 32);
    chk("pushpop_noovf", irq, 0);

    // Completion on top of an unacked BLOCK_DONE, then with ack in same cycle
    for (int i = 0; i < 4; i++) sample(32'h1_0000 + 32'(i) * 4, 1'b0, 1'b1);
    chk("bd3_status", irq_status, 32'h0004_0001);
    sample(32'h1_0100, 1'b0, 1'b1);
    sample(32'h1_0104, 1'b1, 1'b1);
    chk("lost_status", irq_status, 32'h0002_0043);
    chk("done_armed", armed, 0);
    pulse_arm();
    tick();
    sample(32'h1_0200, 1'b0, 1'b1);
    pulse_arm();  // ignored while armed: count must carry on
    irq_ack = 1'b1;
    sample(32'h1_0204, 1'b1, 1'b1);
    irq_ack = 1'b0;
    chk("evack_status", irq_status, 32'h0002_0002);
    chk("evack_irq", irq, 1);

    // Reset in the middle of a fill
    block_size = 16'd8;
    pulse_arm();
    tick();
    for (int i = 0; i < 5; i++) sample(32'h1_0300 + 32'(i) * 4, 1'b0, 1'b1);
    reset = 1'b1;
    tick();
    chk("midrst_armed", armed, 0);
    chk("midrst_level", table_level, 0);
    chk("midrst_irq", irq, 0);
    chk("midrst_dma_wr", dma_wr, 0);
    chk("midrst_status", irq_status, 0);
    reset = 1'b0;
    tick();

`ifdef PCAP_DMA_TIMEOUT_EN
    begin
      int k;
      push(32'h5000);
      push(32'h6000);
      block_size = 16'd16;
      timeout = 32'd100;
      pulse_arm();
      tick();
      for (int i = 0; i < 3; i++) sample(32'h5000 + 32'(i) * 4, 1'b0, 1'b1);
      k = 0;
      while (k < 200 && irq !== 1'b1) begin
        tick();
        k++;
      end
      chk("tmo_cycle", k, 100);
      chk("tmo_status", irq_status, 32'h0003_0021);
      sample(32'h6000, 1'b0, 1'b1);
    end
`endif

    repeat (3) tick();
    chk("sb_drain", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pcap_dma_table.md
PCAP_DMA_TABLE -- requirements
Module: pcap_dma_table

Interface
REQ-001 SHALL have parameter TABLE_DEPTH, default 32, buffer-address table entries (power of 2, 4..256).
REQ-002 SHALL have parameter DATA_W, default 32, sample word width (32 or 64).
REQ-003 SHALL have parameter COUNT_W, default 16, per-buffer word count width (8..16).
REQ-004 SHALL have port clk_i  in  1  single clock; the block has one clock.
REQ-005 SHALL have port reset_i  in  1  reset, synchronous, active-high.
REQ-006 SHALL have ports addr_wr_i in 1, addr_i in 32: push one buffer base address into the table.
REQ-007 SHALL have port block_size_i  in  COUNT_W  words per buffer (0 treated as 2^COUNT_W).
REQ-008 SHALL have ports arm_i in 1, disarm_i in 1: single-cycle capture arm/disarm pulses.
REQ-009 SHALL have ports smpl_valid_i in 1, smpl_last_i in 1, smpl_data_i in DATA_W: sample stream.
REQ-010 SHALL have ports dma_wr_o out 1, dma_addr_o out 32, dma_data_o out DATA_W: write request.
REQ-011 SHALL have ports irq_o out 1, irq_status_o out 32, irq_ack_i in 1: interrupt with status and ack.
REQ-012 SHALL have ports armed_o out 1, table_level_o out $clog2(TABLE_DEPTH)+1.

Function
REQ-013 SHALL implement states IDLE, WAIT_BUF, FILL.
REQ-014 IDLE: arm_i -> WAIT_BUF, word count cleared; smpl_valid_i ignored.
REQ-015 WAIT_BUF: table non-empty -> pop head into current base, -> FILL on the next edge.
REQ-016 WAIT_BUF with table empty and smpl_valid_i: sample dropped, NO_BUFFER flag raised.
REQ-017 FILL: each smpl_valid_i registers dma_wr_o=1 one cycle later, dma_addr_o=base+count*(DATA_W/8), count+1.
REQ-018 Word completing block_size_i SHALL raise BLOCK_DONE with that count.
REQ-019 At BLOCK_DONE, table non-empty SHALL pop the next base on the same edge (zero-bubble), else -> WAIT_BUF.
REQ-020 smpl_last_i with smpl_valid_i SHALL write that word, raise COMPLETED with the final count, -> IDLE.
REQ-021 disarm_i in any state SHALL write nothing further, raise DISARMED with the current count, -> IDLE.
REQ-022 disarm_i and smpl_valid_i in the same cycle: disarm wins, sample dropped.
REQ-023 The table is a circular FIFO; on addr_wr_i when full the write is dropped and TABLE_OVF is raised.
REQ-024 Simultaneous push and pop when full SHALL both succeed with the level unchanged.
REQ-025 irq_status_o: [31:16] word count (zero-extended), [6:0] flags BLOCK_DONE, COMPLETED, DISARMED, NO_BUFFER, TABLE_OVF, TIMEOUT, IRQ_LOST.
REQ-026 An event SHALL set irq_o and load irq_status_o on the next edge.
REQ-027 irq_ack_i SHALL clear irq_o and irq_status_o on the next edge.
REQ-028 An event while irq_o is set and unacked SHALL OR its flags in, set IRQ_LOST, and overwrite the count.
REQ-029 Event and ack in the same cycle: the new status SHALL load, irq_o stays 1, no IRQ_LOST.
REQ-030 armed_o SHALL be 1 in WAIT_BUF and FILL; arm_i while armed SHALL be ignored.

Reset
REQ-031 reset_i SHALL force IDLE, clear the table (level 0), count 0, and all outputs to 0, mid-operation included.

Configuration
REQ-032 With PCAP_DMA_TIMEOUT_EN defined: add input timeout_i (32); in FILL with count>0, timeout_i!=0, and timeout_i cycles without a sample -> raise TIMEOUT|BLOCK_DONE with the partial count, advance buffer per REQ-019.
REQ-033 Without PCAP_DMA_TIMEOUT_EN: no timeout_i port, TIMEOUT flag always 0, no timer logic.

Structure
REQ-034 Package pcap_dma_pkg SHALL hold the state enum, flag bit positions, and the status field offsets.
REQ-035 The table SHALL be sub-module pcap_addr_fifo (parametrised depth/width, push/pop/level/full/empty).

Verification
REQ-036 Push 0x1000,0x2000; block_size 4; arm; 8 samples back-to-back -> writes at 0x1000..0x100C, 0x2000..0x200C with no gap; two BLOCK_DONE events with count 4.
REQ-037 Table empty, arm, 3 samples -> no dma_wr_o; NO_BUFFER set; push 0x3000 then 1 sample -> write at 0x3000.
REQ-038 Push 33 addresses at depth 32 -> level 32, TABLE_OVF set; push and pop together at full -> level stays 32.
REQ-039 Sample 2 with smpl_last_i, irq unacked from a prior BLOCK_DONE -> status 0x0002_0043 (COMPLETED|BLOCK_DONE|IRQ_LOST); ack in the same cycle as the event -> 0x0002_0002.
REQ-040 reset_i mid-FILL at count 5 -> next cycle IDLE, level 0, irq_o 0, dma_wr_o 0.
REQ-041 With PCAP_DMA_TIMEOUT_EN, timeout 100, 3 samples then idle -> at cycle 100 irq with status 0x0003_0021.
